// File: rtl/usb_request_sequencer_if.sv
// -----------------------------------------------------------------------------
// usb_request_sequencer_if
// Purpose : bundles every non-clock signal between the request sequencer, the
//           request table, the USB transmit/receive engine and the
//           controller-facing logic.
// Modports:
//   master - the sequencer view (drives reqIndex, transmit*, report*, status)
//   slave  - the environment view (drives restart, engine strobes, table data)
// Signals :
//   restart        1-cycle abort/restart request
//   transmitEnd    engine finished current transfer (1-cycle pulse)
//   recieveValid   recieveBuffer/recieveSize valid (1-cycle pulse)
//   recieveBuffer  received data, BUF_WIDTH
//   recieveSize    received byte count, SIZE_WIDTH
//   reqIndex       request table index, IDXW
//   reqBuffer      table payload for reqIndex (combinational)
//   reqSize        table byte count for reqIndex; 0 = skip entry
//   transmitBuffer request payload presented to the engine
//   transmitSize   request byte count presented to the engine
//   startTransmit  1-cycle launch pulse
//   reportBuffer   last captured controller report
//   reportSize     last captured report byte count
//   reportValid    1-cycle pulse on report capture
//   initDone       init script complete
//   error          sticky init failure
//   missCount      saturating count of poll timeouts
// -----------------------------------------------------------------------------
interface usb_request_sequencer_if #(
  parameter int BUF_WIDTH  = 512,
  parameter int SIZE_WIDTH = 10,
  parameter int NUM_INIT   = 2
);
  localparam int IDXW = $clog2(NUM_INIT + 1);

  logic                  restart;
  logic                  transmitEnd;
  logic                  recieveValid;
  logic [BUF_WIDTH-1:0]  recieveBuffer;
  logic [SIZE_WIDTH-1:0] recieveSize;
  logic [IDXW-1:0]       reqIndex;
  logic [BUF_WIDTH-1:0]  reqBuffer;
  logic [SIZE_WIDTH-1:0] reqSize;
  logic [BUF_WIDTH-1:0]  transmitBuffer;
  logic [SIZE_WIDTH-1:0] transmitSize;
  logic                  startTransmit;
  logic [BUF_WIDTH-1:0]  reportBuffer;
  logic [SIZE_WIDTH-1:0] reportSize;
  logic                  reportValid;
  logic                  initDone;
  logic                  error;
  logic [7:0]            missCount;

  modport master (
    input  restart, transmitEnd, recieveValid, recieveBuffer, recieveSize,
           reqBuffer, reqSize,
    output reqIndex, transmitBuffer, transmitSize, startTransmit,
           reportBuffer, reportSize, reportValid, initDone, error, missCount
  );

  modport slave (
    output restart, transmitEnd, recieveValid, recieveBuffer, recieveSize,
           reqBuffer, reqSize,
    input  reqIndex, transmitBuffer, transmitSize, startTransmit,
           reportBuffer, reportSize, reportValid, initDone, error, missCount
  );
endinterface

// File: rtl/usb_request_sequencer.sv
// -----------------------------------------------------------------------------
// usb_request_sequencer
// Purpose : host-side USB request sequencer for game-controller bring-up.
//           After a startup delay it walks an external request table
//           (indices 0..NUM_INIT-1) with per-request timeout and retry, then
//           periodically launches the poll request (index NUM_INIT) and
//           captures each controller report returned during a poll.
// Ports   :
//   HPS_USB_CLKOUT  clock
//   resetN          asynchronous reset, active-low
//   bus             usb_request_sequencer_if.master (see interface header)
// -----------------------------------------------------------------------------
module usb_request_sequencer #(
  parameter int BUF_WIDTH      = 512,
  parameter int SIZE_WIDTH     = 10,
  parameter int NUM_INIT       = 2,
  parameter int STARTUP_CYCLES = 150_000_000,
  parameter int GAP_CYCLES     = 50_000,
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int MAX_RETRIES    = 3,
  parameter int POLL_PERIOD    = 500_000
) (
  input  logic                      HPS_USB_CLKOUT,
  input  logic                      resetN,
  usb_request_sequencer_if.master   bus
);

  localparam int IDXW = $clog2(NUM_INIT + 1);
  localparam int RW   = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    S_STARTUP,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_GAP,
    S_POLL_GAP,
    S_ERROR
  } state_t;

  state_t                r_state,     w_state_next;
  logic [IDXW-1:0]       r_idx,       w_idx_next;
  logic [RW-1:0]         r_retries,   w_retries_next;
  logic [31:0]           r_cnt,       w_cnt_next;
  logic [BUF_WIDTH-1:0]  r_tx_buf,    w_tx_buf_next;
  logic [SIZE_WIDTH-1:0] r_tx_size,   w_tx_size_next;
  logic                  r_init_done, w_init_done_next;
  logic [7:0]            r_miss,      w_miss_next;
  logic [BUF_WIDTH-1:0]  r_rep_buf;
  logic [SIZE_WIDTH-1:0] r_rep_size;
  logic                  r_rep_valid;
  logic                  w_advance;
  logic                  w_capture;
  logic                  w_tx_active;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge HPS_USB_CLKOUT or negedge resetN) begin
    if (!resetN) begin
      r_state     <= S_STARTUP;
      r_idx       <= '0;
      r_retries   <= '0;
      r_cnt       <= '0;
      r_tx_buf    <= '0;
      r_tx_size   <= '0;
      r_init_done <= 1'b0;
      r_miss      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_retries   <= w_retries_next;
      r_cnt       <= w_cnt_next;
      r_tx_buf    <= w_tx_buf_next;
      r_tx_size   <= w_tx_size_next;
      r_init_done <= w_init_done_next;
      r_miss      <= w_miss_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_retries_next   = r_retries;
    w_cnt_next       = r_cnt + 32'd1;
    w_tx_buf_next    = r_tx_buf;
    w_tx_size_next   = r_tx_size;
    w_init_done_next = r_init_done;
    w_miss_next      = r_miss;
    w_advance        = 1'b0;

    if (bus.restart) begin
      // Restart beats every same-cycle event; the report is left untouched.
      w_state_next     = S_STARTUP;
      w_idx_next       = '0;
      w_retries_next   = '0;
      w_init_done_next = 1'b0;
      w_miss_next      = '0;
    end else begin
      case (r_state)
        S_STARTUP: begin
          if (r_cnt == 32'(STARTUP_CYCLES - 1)) w_state_next = S_LOAD;
        end
        S_LOAD: begin
          // A zero-length entry is a no-op that still counts as success.
          if (bus.reqSize == '0) begin
            w_advance = 1'b1;
          end else begin
            w_tx_buf_next  = bus.reqBuffer;
            w_tx_size_next = bus.reqSize;
            w_state_next   = S_SEND;
          end
        end
        S_SEND: begin
          w_state_next = S_WAIT;
        end
        S_WAIT: begin
          // transmitEnd wins over a coincident timeout.
          if (bus.transmitEnd) begin
            w_retries_next = '0;
            w_advance      = 1'b1;
          end else if (r_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            if (!r_init_done) begin
              w_retries_next = r_retries + RW'(1);
              if (r_retries == RW'(MAX_RETRIES - 1)) w_state_next = S_ERROR;
              else                                   w_state_next = S_SEND;
            end else begin
              if (r_miss != 8'hFF) w_miss_next = r_miss + 8'd1;
              w_state_next = S_POLL_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_cnt == 32'(GAP_CYCLES - 1)) w_state_next = S_LOAD;
        end
        S_POLL_GAP: begin
          if (r_cnt == 32'(POLL_PERIOD - 1)) begin
            w_idx_next   = IDXW'(NUM_INIT);
            w_state_next = S_LOAD;
          end
        end
        S_ERROR: begin
          w_cnt_next = '0;
        end
        default: begin
          w_state_next = S_STARTUP;
        end
      endcase

      if (w_advance) begin
        if (r_init_done) begin
          w_state_next = S_POLL_GAP;
        end else if (r_idx < IDXW'(NUM_INIT - 1)) begin
          w_idx_next   = r_idx + IDXW'(1);
          w_state_next = S_GAP;
        end else begin
          w_init_done_next = 1'b1;
          w_idx_next       = IDXW'(NUM_INIT);
          w_state_next     = S_POLL_GAP;
        end
      end
    end

    // Every state that counts starts from zero on entry.
    if (w_state_next != r_state) w_cnt_next = '0;
  end

  // ---------------------------------------------------------------------------
  // Report capture: only during a poll-phase wait, transmitEnd cycle included.
  // ---------------------------------------------------------------------------
  assign w_capture = bus.recieveValid && (r_state == S_WAIT) && r_init_done &&
                     !bus.restart;

  always_ff @(posedge HPS_USB_CLKOUT or negedge resetN) begin
    if (!resetN) begin
      r_rep_buf   <= '0;
      r_rep_size  <= '0;
      r_rep_valid <= 1'b0;
    end else begin
      r_rep_valid <= w_capture;
      if (w_capture) begin
        r_rep_buf  <= bus.recieveBuffer;
        r_rep_size <= bus.recieveSize;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign w_tx_active = (r_state == S_SEND) || (r_state == S_WAIT);

  assign bus.reqIndex       = r_idx;
  assign bus.transmitBuffer = w_tx_active ? r_tx_buf  : '0;
  assign bus.transmitSize   = w_tx_active ? r_tx_size : '0;
  assign bus.startTransmit  = (r_state == S_SEND);
  assign bus.reportBuffer   = r_rep_buf;
  assign bus.reportSize     = r_rep_size;
  assign bus.reportValid    = r_rep_valid;
  assign bus.initDone       = r_init_done;
  assign bus.error          = (r_state == S_ERROR);
  assign bus.missCount      = r_miss;

endmodule
